// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches, buffers
// returned words with their PCs and hands them to decode over valid/ready.
// A redirect flushes the buffer and marks in-flight responses for discard.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        redirect_misaligned,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          misalign_q, misalign_d;

    logic [31:0]   fifo_pc_q  [FIFO_DEPTH];
    logic [31:0]   fifo_ins_q [FIFO_DEPTH];

    logic [CW:0]   credit_used;
    logic          accept;
    logic          rsp_fire;
    logic          dropping;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_tgt;
    logic [CW-1:0] redirect_drop;

    // Buffered plus in-flight words never exceed the buffer size, so a
    // response always has a free slot and no overflow check is needed.
    assign credit_used    = {1'b0, count_q} + {1'b0, outstanding_q};
    assign imem_req_valid = !rst && !redirect_valid &&
                            (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is spurious and ignored entirely.
    assign rsp_fire  = imem_rsp_valid && (outstanding_q != '0);
    assign dropping  = (drop_q != '0);
    assign push      = rsp_fire && !dropping && !redirect_valid;
    assign pop       = id_valid && id_ready && !redirect_valid;

    assign redirect_tgt  = {redirect_pc[31:2], 2'b00};
    assign redirect_drop = outstanding_q - CW'(rsp_fire);

    assign id_valid            = (count_q != '0);
    assign id_instruction      = id_valid ? fifo_ins_q[rd_ptr_q] : 32'h0;
    assign id_pc               = id_valid ? fifo_pc_q[rd_ptr_q]  : 32'h0;
    assign redirect_misaligned = misalign_q;

    // Next-state for PC tracking, in-flight accounting and buffer pointers.
    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        misalign_d    = redirect_valid && (redirect_pc[1:0] != 2'b00);

        if (redirect_valid) begin
            // Everything still in flight belongs to the old stream; the
            // response landing this cycle is consumed and discarded here.
            pc_d          = redirect_tgt;
            rsp_pc_d      = redirect_tgt;
            drop_d        = redirect_drop;
            outstanding_d = redirect_drop;
            count_d       = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
        end else begin
            if (accept) begin
                pc_d = pc_q + 32'd4;
            end
            outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_fire);
            if (rsp_fire && dropping) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            misalign_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            misalign_q    <= misalign_d;
        end
    end

    // Buffer storage; contents are don't-care while empty since outputs are gated.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]  <= rsp_pc_q;
            fifo_ins_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-configurable memory model plus a scoreboard of
// expected {pc, instr} pairs pushed on request accept and popped on decode.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_misaligned;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;

    fetch_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .imem_req_valid      (imem_req_valid),
        .imem_req_ready      (imem_req_ready),
        .imem_req_addr       (imem_req_addr),
        .imem_rsp_valid      (imem_rsp_valid),
        .imem_rsp_data       (imem_rsp_data),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .redirect_misaligned (redirect_misaligned),
        .id_valid            (id_valid),
        .id_ready            (id_ready),
        .id_instruction      (id_instruction),
        .id_pc               (id_pc)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // addi x(n+1), x0, n for word n: 0x0 -> 0x00000093, 0x4 -> 0x00100113
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        return (w << 20) | (((w + 32'd1) & 32'd31) << 7) | 32'h13;
    endfunction

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;

    mreq_t pend[$];
    exp_t  sb[$];
    int    lat    = 1;
    int    cyc    = 0;
    bit    inject = 1'b0;

    // Memory model and scoreboard; inputs change just after posedge, so
    // everything is stable here for the coming edge.
    always @(negedge clk) begin : mem_sb
        mreq_t r;
        exp_t  e;
        cyc++;
        if (rst) begin
            pend.delete();
            sb.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end else begin
            if (redirect_valid) begin
                sb.delete();
            end else if (id_valid && id_ready) begin
                chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_pc", id_pc, e.pc);
                    chk("sb_instr", id_instruction, e.ins);
                end
            end
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                r = pend.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(r.addr);
            end
            if (inject) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hDEAD_BEEF;
                inject         = 1'b0;
            end
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back('{imem_req_addr, cyc + lat});
                sb.push_back('{imem_req_addr, mem_word(imem_req_addr)});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_id(input string tag);
        int n = 0;
        while (!id_valid && n < 50) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, id_valid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        #1;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_misalign", {31'b0, redirect_misaligned}, 32'd0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instruction, 32'h0);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("c0_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("c0_req_addr", imem_req_addr, 32'h0);
        tick();
        chk("c1_req_addr", imem_req_addr, 32'h4);
        chk("c1_id_valid", {31'b0, id_valid}, 32'd0);
        tick();
        chk("c2_id_valid", {31'b0, id_valid}, 32'd1);
        chk("c2_id_pc", id_pc, 32'h0);
        chk("c2_id_instr", id_instruction, 32'h0000_0093);
        chk("c2_req_addr", imem_req_addr, 32'h8);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("stream_valid", {31'b0, id_valid}, 32'd1);
            chk("stream_pc", id_pc, 32'(4 * k));
        end

        // decode stall: credits exhaust, then stream resumes in order
        id_ready = 1'b0;
        repeat (10) tick();
        chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("stall_id_valid", {31'b0, id_valid}, 32'd1);
        id_ready = 1'b1;
        repeat (4) tick();

        // memory request stall: address and valid held
        imem_req_ready = 1'b0;
        #1;
        a = imem_req_addr;
        chk("hold_valid0", {31'b0, imem_req_valid}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_addr", imem_req_addr, a);
            chk("hold_valid", {31'b0, imem_req_valid}, 32'd1);
        end
        imem_req_ready = 1'b1;
        repeat (3) tick();

        // 3-cycle memory, redirect with responses in flight
        lat = 3;
        repeat (6) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        chk("redir_no_req", {31'b0, imem_req_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("redir_addr", imem_req_addr, 32'h100);
        chk("redir_empty", {31'b0, id_valid}, 32'd0);
        wait_id("redir_wait");
        chk("redir_pc", id_pc, 32'h100);
        chk("redir_instr", id_instruction, mem_word(32'h100));

        // back-to-back redirects: last target wins
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("b2b_addr", imem_req_addr, 32'h300);
        wait_id("b2b_wait");
        chk("b2b_pc", id_pc, 32'h300);

        // 1-cycle memory, misaligned redirect coinciding with a pop
        lat = 1;
        repeat (8) tick();
        chk("pre_redir_valid", {31'b0, id_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        #1;
        chk("mis_no_req", {31'b0, imem_req_valid}, 32'd0);
        chk("mis_pre", {31'b0, redirect_misaligned}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        chk("mis_hi", {31'b0, redirect_misaligned}, 32'd1);
        chk("mis_addr", imem_req_addr, 32'h100);
        chk("pop_void_empty", {31'b0, id_valid}, 32'd0);
        tick();
        chk("mis_lo", {31'b0, redirect_misaligned}, 32'd0);
        chk("lat_n2_valid", {31'b0, id_valid}, 32'd0);
        tick();
        chk("lat_n3_valid", {31'b0, id_valid}, 32'd1);
        chk("lat_n3_pc", id_pc, 32'h100);
        chk("lat_n3_instr", id_instruction, mem_word(32'h100));

        // asynchronous reset mid-stream, then a spurious response
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        inject = 1'b1;
        #1;
        chk("rr_c0_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("rr_c0_addr", imem_req_addr, 32'h0);
        tick();
        chk("rr_c1_id_valid", {31'b0, id_valid}, 32'd0);
        tick();
        chk("rr_c2_id_valid", {31'b0, id_valid}, 32'd1);
        chk("rr_c2_pc", id_pc, 32'h0);
        chk("rr_c2_instr", id_instruction, 32'h0000_0093);
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
